// File: rtl/sha256_block_scheduler.sv
// Sequencer for SHA-256 message expansion: accepts one 512-bit block, steps the
// expansion through ROUNDS W words toward compression, then strobes digest update.
module sha256_block_scheduler #(
    parameter int ROUNDS  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_last,
    output logic [511:0] exp_M,
    output logic         exp_start,
    output logic [4:0]   exp_count,
    input  logic         exp_w_rdy,
    input  logic [31:0]  exp_w,
    output logic         rnd_valid,
    input  logic         rnd_ready,
    output logic [5:0]   rnd_idx,
    output logic [31:0]  rnd_w,
    output logic         rnd_init,
    output logic         fin_en,
    output logic         msg_done,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FIN,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t         r_state;
    logic   [5:0]   r_idx;
    logic           r_last;
    logic           r_first;
    logic   [7:0]   r_tmo;
    logic           r_err;
    logic           r_blk_ready;
    logic   [511:0] r_exp_M;
    logic           r_exp_start;
    logic           r_rnd_valid;
    logic   [5:0]   r_rnd_idx;
    logic   [31:0]  r_rnd_w;
    logic           r_rnd_init;
    logic           r_fin_en;
    logic           r_msg_done;
    logic           r_busy;

    assign blk_ready = r_blk_ready;
    assign exp_M     = r_exp_M;
    assign exp_start = r_exp_start;
    assign exp_count = r_idx[4:0];
    assign rnd_valid = r_rnd_valid;
    assign rnd_idx   = r_rnd_idx;
    assign rnd_w     = r_rnd_w;
    assign rnd_init  = r_rnd_init;
    assign fin_en    = r_fin_en;
    assign msg_done  = r_msg_done;
    assign busy      = r_busy;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_first     <= 1'b1;
            r_tmo       <= '0;
            r_err       <= 1'b0;
            r_blk_ready <= 1'b1;
            r_exp_M     <= '0;
            r_exp_start <= 1'b0;
            r_rnd_valid <= 1'b0;
            r_rnd_idx   <= '0;
            r_rnd_w     <= '0;
            r_rnd_init  <= 1'b0;
            r_fin_en    <= 1'b0;
            r_msg_done  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_exp_start <= 1'b0;
            r_fin_en    <= 1'b0;
            r_msg_done  <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (blk_valid && r_blk_ready) begin
                        r_exp_M     <= blk_data;
                        r_last      <= blk_last;
                        r_idx       <= '0;
                        r_tmo       <= '0;
                        r_rnd_init  <= r_first;
                        r_blk_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_exp_start <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_state <= S_ROUND;
                end

                // A held word blocks capture, so a transfer and a capture never share a cycle.
                S_ROUND: begin
                    if (r_rnd_valid) begin
                        if (rnd_ready) begin
                            r_rnd_valid <= 1'b0;
                            r_idx       <= (r_idx == LAST_IDX) ? '0 : r_idx + 6'd1;
                            if (r_idx == LAST_IDX) begin
                                r_fin_en <= 1'b1;
                                r_state  <= S_FIN;
                            end
                        end
                    end else if (exp_w_rdy) begin
                        r_rnd_w     <= exp_w;
                        r_rnd_idx   <= r_idx;
                        r_rnd_valid <= 1'b1;
                        r_tmo       <= '0;
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end

                S_FIN: begin
                    if (r_last) begin
                        r_msg_done <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_first     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_blk_ready <= !r_err;
                        r_state     <= S_IDLE;
                    end
                end

                S_DONE: begin
                    r_first     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_blk_ready <= !r_err;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
